// File: rtl/div_core.sv
// -----------------------------------------------------------------------------
// div_core -- multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   div_start_i      operation request (level, held by the ALU until ready)
//   div_op_i         00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//   dividend_i       dividend (rs1), sampled with start
//   divisor_i        divisor (rs2), sampled with start
//   flush_i          pipeline flush, aborts any operation and clears the result
//   div_result_o     registered quotient or remainder
//   div_res_ready_o  one-cycle result-valid pulse
//   div_busy_o       high while iterating
//
// Divide-by-zero and signed overflow skip the iteration and complete in one
// cycle. All other operations run one quotient bit per cycle on magnitudes;
// the sign is fixed up on the edge that loads the result.
// -----------------------------------------------------------------------------
module div_core #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_start_i,
    input  logic [1:0]            div_op_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] div_result_o,
    output logic                  div_res_ready_o,
    output logic                  div_busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    // Two's-complement negate when en is set, pass through otherwise.
    function automatic logic [DATA_WIDTH-1:0] neg_if(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  en
    );
        logic [DATA_WIDTH-1:0] r;
        if (en) begin
            r = ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic                  is_rem_q, is_rem_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    // Iteration datapath: {rem,quot} shifted left by one; the quot register
    // starts as the dividend magnitude, so its MSB is the next dividend bit.
    logic [DATA_WIDTH:0]   partial_s;
    logic [DATA_WIDTH:0]   trial_s;
    logic [DATA_WIDTH-1:0] rem_next_s;
    logic [DATA_WIDTH-1:0] quot_next_s;

    // Trial subtraction; the extra MSB is the borrow that selects restore.
    always_comb begin
        partial_s   = {rem_q, quot_q[DATA_WIDTH-1]};
        trial_s     = partial_s - {1'b0, divisor_q};
        rem_next_s  = trial_s[DATA_WIDTH] ? partial_s[DATA_WIDTH-1:0]
                                          : trial_s[DATA_WIDTH-1:0];
        quot_next_s = {quot_q[DATA_WIDTH-2:0], ~trial_s[DATA_WIDTH]};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        is_rem_d  = is_rem_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        result_d  = result_q;
        ready_d   = 1'b0;

        if (flush_i) begin
            state_d  = IDLE;
            result_d = ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_start_i) begin
                        if (divisor_i == ZERO) begin
                            state_d  = DONE;
                            ready_d  = 1'b1;
                            result_d = div_op_i[1] ? dividend_i : ALL_ONES;
                        end else if (!div_op_i[0] && (dividend_i == MIN_NEG) &&
                                     (divisor_i == ALL_ONES)) begin
                            state_d  = DONE;
                            ready_d  = 1'b1;
                            result_d = div_op_i[1] ? ZERO : MIN_NEG;
                        end else begin
                            state_d   = CALC;
                            cnt_d     = CNT_ZERO;
                            rem_d     = ZERO;
                            is_rem_d  = div_op_i[1];
                            // div_op_i[0]==0 marks the signed variants.
                            quot_d    = neg_if(dividend_i,
                                               !div_op_i[0] && dividend_i[DATA_WIDTH-1]);
                            divisor_d = neg_if(divisor_i,
                                               !div_op_i[0] && divisor_i[DATA_WIDTH-1]);
                            q_neg_d   = !div_op_i[0] &&
                                        (dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1]);
                            r_neg_d   = !div_op_i[0] && dividend_i[DATA_WIDTH-1];
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    rem_d  = rem_next_s;
                    quot_d = quot_next_s;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        result_d = is_rem_q ? neg_if(rem_next_s, r_neg_q)
                                            : neg_if(quot_next_s, q_neg_q);
                    end else begin
                        state_d = CALC;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == CALC);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            rem_q     <= ZERO;
            quot_q    <= ZERO;
            divisor_q <= ZERO;
            is_rem_q  <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= ZERO;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            is_rem_q  <= is_rem_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign div_result_o    = result_q;
    assign div_res_ready_o = ready_q;
    assign div_busy_o      = busy_q;

endmodule

// File: tb/tb_div_core.sv
// -----------------------------------------------------------------------------
// tb_div_core -- self-checking bench for div_core.
// Cycle k is the k-th clock period after the one in which start was first
// driven (cycle 0). Inputs change and outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_div_core;

    logic        clk;
    logic        rst_n;
    logic        div_start_i;
    logic [1:0]  div_op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        flush_i;
    logic [31:0] div_result_o;
    logic        div_res_ready_o;
    logic        div_busy_o;

    int checks   = 0;
    int failures = 0;

    div_core #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .div_start_i     (div_start_i),
        .div_op_i        (div_op_i),
        .dividend_i      (dividend_i),
        .divisor_i       (divisor_i),
        .flush_i         (flush_i),
        .div_result_o    (div_result_o),
        .div_res_ready_o (div_res_ready_o),
        .div_busy_o      (div_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M reference semantics using plain language arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'h0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation, check latency, busy profile, result, pulse width.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        bit          busy_ok;
        exp     = ref_div(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : 33;
        @(negedge clk);
        div_op_i    = op;
        dividend_i  = a;
        divisor_i   = b;
        div_start_i = 1'b1;
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (div_busy_o !== (k < exp_lat)) busy_ok = 1'b0;
            if (div_res_ready_o === 1'b1) begin
                lat = k;
                break;
            end
        end
        div_start_i = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, div_result_o, exp);
        chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, div_res_ready_o}, 32'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          early_ready;
        int          ready_cnt;

        rst_n       = 1'b0;
        div_start_i = 1'b0;
        div_op_i    = 2'b00;
        dividend_i  = 32'h0;
        divisor_i   = 32'h0;
        flush_i     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_result", div_result_o, 32'h0);
        chk("reset_ready", {31'd0, div_res_ready_o}, 32'd0);
        chk("reset_busy", {31'd0, div_busy_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations.
        do_op(2'b01, 32'd100, 32'd7, "divu_100_7");
        do_op(2'b11, 32'd100, 32'd7, "remu_100_7");
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
        do_op(2'b00, 32'h1234, 32'h0, "div_by_zero");
        do_op(2'b11, 32'h1234, 32'h0, "remu_by_zero");
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_ovf");
        do_op(2'b01, 32'hFFFF_FFFF, 32'h1, "divu_max_1");

        // Flush mid-CALC, then a new op from cycle 12: ready only in cycle 45.
        early_ready = 1'b0;
        ready_cnt   = 0;
        @(negedge clk);
        div_op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; div_start_i = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (div_res_ready_o === 1'b1) begin
                ready_cnt++;
                if (k != 45) early_ready = 1'b1;
                if (k == 45) chk("flush_new_result", div_result_o, 32'd3);
                div_start_i = 1'b0;
            end
            if (k == 11) begin
                chk("flush_result_cleared", div_result_o, 32'h0);
                chk("flush_busy_cleared", {31'd0, div_busy_o}, 32'd0);
            end
            flush_i = (k == 10);
            if (k == 10) div_start_i = 1'b0;
            if (k == 12) begin
                div_op_i = 2'b01; dividend_i = 32'd9; divisor_i = 32'd3; div_start_i = 1'b1;
            end
        end
        chk("flush_no_stray_ready", {31'd0, early_ready}, 32'd0);
        chk("flush_ready_count", 32'(ready_cnt), 32'd1);

        // Flush during DONE: pulse still visible, result cleared next edge.
        @(negedge clk);
        div_op_i = 2'b01; dividend_i = 32'h55; divisor_i = 32'h0; div_start_i = 1'b1;
        @(negedge clk);
        chk("done_flush_ready", {31'd0, div_res_ready_o}, 32'd1);
        chk("done_flush_result", div_result_o, 32'hFFFF_FFFF);
        div_start_i = 1'b0;
        flush_i     = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("done_flush_cleared", div_result_o, 32'h0);
        chk("done_flush_ready_low", {31'd0, div_res_ready_o}, 32'd0);

        // Flush together with start in IDLE: nothing latched.
        @(negedge clk);
        div_op_i = 2'b01; dividend_i = 32'd10; divisor_i = 32'd2; div_start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        div_start_i = 1'b0; flush_i = 1'b0;
        chk("flush_start_busy", {31'd0, div_busy_o}, 32'd0);
        @(negedge clk);

        // Start held through ready: second op re-sampled in cycle 34.
        ready_cnt   = 0;
        early_ready = 1'b0;
        div_op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; div_start_i = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (div_res_ready_o === 1'b1) begin
                ready_cnt++;
                if (k == 33) chk("held_first_result", div_result_o, 32'd14);
                else if (k == 67) chk("held_second_result", div_result_o, 32'd10);
                else early_ready = 1'b1;
            end
            if (k == 33) begin dividend_i = 32'd50; divisor_i = 32'd5; end
            if (k == 67) div_start_i = 1'b0;
        end
        chk("held_ready_count", 32'(ready_cnt), 32'd2);
        chk("held_no_stray_ready", {31'd0, early_ready}, 32'd0);

        // Reset asserted mid-CALC takes effect without a clock edge.
        div_op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; div_start_i = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_reset_busy", {31'd0, div_busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, div_busy_o}, 32'd0);
        chk("async_reset_result", div_result_o, 32'h0);
        chk("async_reset_ready", {31'd0, div_res_ready_o}, 32'd0);
        div_start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'h0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
